seq_shifter: RTL and testbench

- Multi-cycle iterative shifter for the KGP_RISC ALU shift instructions: SLL, SRL and SRA, with both constant and register shift amounts.
- It shifts by at most STEP bits per cycle instead of using a full log-depth mux tree, trading latency for area.
- It is the control-driven, handshaked counterpart to the combinational shift path.
- The control unit issues a start and stalls on busy; the result is returned with a done pulse.

---
 rtl/seq_shifter.sv | 124 ++++++++++++
 tb/tb_seq_shifter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle iterative shifter (SLL/SRL/SRA) moving at most STEP bits per cycle.
// Handshaked: start accepted in IDLE, busy while working, one-cycle done with result.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inp,
    input  logic             dir,
    input  logic             arith,
    input  logic [31:0]      shiftamt,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] work_r, work_nxt_s, shifted_s, out_r, out_nxt_s;
    logic [CW-1:0]    rem_r, rem_nxt_s, eff_s, step_s;
    logic             dir_r, dir_nxt_s, fill_r, fill_nxt_s;
    logic             busy_r, busy_nxt_s, done_r, done_nxt_s;

    // Effective amount saturates at WIDTH, per-cycle step and one shifted iteration
    always_comb begin
        eff_s     = {CW{1'b0}};
        step_s    = {CW{1'b0}};
        shifted_s = work_r;
        if (shiftamt >= 32'(WIDTH)) begin
            eff_s = CW'(WIDTH);
        end else begin
            eff_s = shiftamt[CW-1:0];
        end
        if (rem_r < CW'(STEP)) begin
            step_s = rem_r;
        end else begin
            step_s = CW'(STEP);
        end
        // The fill mask covers exactly the bits vacated by a right shift
        if (dir_r) begin
            shifted_s = (work_r >> step_s) |
                        ({WIDTH{fill_r}} & ~({WIDTH{1'b1}} >> step_s));
        end else begin
            shifted_s = work_r << step_s;
        end
    end

    // Next-state and datapath updates for the IDLE/SHIFT/DONE controller
    always_comb begin
        state_nxt_s = state_r;
        work_nxt_s  = work_r;
        rem_nxt_s   = rem_r;
        dir_nxt_s   = dir_r;
        fill_nxt_s  = fill_r;
        out_nxt_s   = out_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    work_nxt_s  = inp;
                    rem_nxt_s   = eff_s;
                    dir_nxt_s   = dir;
                    fill_nxt_s  = dir & arith & inp[WIDTH-1];
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (rem_r != {CW{1'b0}}) begin
                    work_nxt_s = shifted_s;
                    rem_nxt_s  = rem_r - step_s;
                end else begin
                    out_nxt_s   = work_r;
                    state_nxt_s = DONE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
        done_nxt_s = (state_nxt_s == DONE);
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            work_r  <= {WIDTH{1'b0}};
            rem_r   <= {CW{1'b0}};
            dir_r   <= 1'b0;
            fill_r  <= 1'b0;
            out_r   <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            work_r  <= work_nxt_s;
            rem_r   <= rem_nxt_s;
            dir_r   <= dir_nxt_s;
            fill_r  <= fill_nxt_s;
            out_r   <= out_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign out  = out_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: STEP=1 and STEP=4 instances, scoreboard of
// expected results and latencies, start-while-busy and asynchronous mid-operation reset.
module tb_seq_shifter;

    logic        clk;
    logic        rst;
    logic        start1, start4;
    logic [31:0] inp;
    logic        dir, arith;
    logic [31:0] shiftamt;
    logic [31:0] out1, out4;
    logic        busy1, busy4, done1, done4;
    logic        use4;
    logic [31:0] cur_out;
    logic        cur_busy, cur_done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    seq_shifter #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .inp(inp), .dir(dir), .arith(arith),
        .shiftamt(shiftamt), .out(out1), .busy(busy1), .done(done1)
    );

    seq_shifter #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .inp(inp), .dir(dir), .arith(arith),
        .shiftamt(shiftamt), .out(out4), .busy(busy4), .done(done4)
    );

    assign cur_out  = use4 ? out4  : out1;
    assign cur_busy = use4 ? busy4 : busy1;
    assign cur_done = use4 ? done4 : done1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial reference: one position per iteration with the chosen fill
    function automatic logic [31:0] model(input logic [31:0] a, input logic d,
                                          input logic ar, input logic [31:0] amt);
        logic [31:0] x;
        int          e;
        logic        f;
        x = a;
        e = (amt >= 32'd32) ? 32 : int'(amt);
        f = d & ar & a[31];
        for (int i = 0; i < e; i++) begin
            if (d) x = {f, x[31:1]};
            else   x = {x[30:0], 1'b0};
        end
        return x;
    endfunction

    task automatic run_op(input logic sel, input logic [31:0] a, input logic d,
                          input logic ar, input logic [31:0] amt, input string name);
        int          e, stp, n;
        logic        got;
        logic [31:0] exp_v;
        int          exp_lat;
        use4 = sel;
        stp  = sel ? 4 : 1;
        e    = (amt >= 32'd32) ? 32 : int'(amt);
        exp_q.push_back(model(a, d, ar, amt));
        lat_q.push_back((e + stp - 1) / stp + 1);
        @(negedge clk);
        inp = a; dir = d; arith = ar; shiftamt = amt;
        if (sel) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        inp = $urandom; dir = ~d; arith = ~ar; shiftamt = $urandom_range(31, 0);
        checks++;
        if (cur_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_rise: got %b want 1", name, cur_busy);
        end
        n = 0; got = 1'b0;
        while (n < 200 && !got) begin
            @(posedge clk); #1;
            n++;
            if (cur_done === 1'b1) got = 1'b1;
        end
        exp_v   = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s done_timeout: got no done want done after %0d cycles", name, exp_lat);
        end else begin
            checks++;
            if (n != exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
            end
            checks++;
            if (cur_out !== exp_v) begin
                errors++;
                $display("FAIL %s result: got %h want %h", name, cur_out, exp_v);
            end
            @(posedge clk); #1;
            checks++;
            if (cur_done !== 1'b0 || cur_busy !== 1'b0 || cur_out !== exp_v) begin
                errors++;
                $display("FAIL %s after_done: got done=%b busy=%b out=%h want 0 0 %h",
                         name, cur_done, cur_busy, cur_out, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0; use4 = 1'b0;
        inp = 32'h0; dir = 1'b0; arith = 1'b0; shiftamt = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out1 !== 32'h0 || busy1 !== 1'b0 || done1 !== 1'b0 ||
            out4 !== 32'h0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h %b %b %h %b %b want all zero",
                     out1, busy1, done1, out4, busy4, done4);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_logical_right();
        run_op(1'b0, 32'h0F0F0F0F, 1'b1, 1'b0, 32'd13, "srl13");
        run_op(1'b0, 32'h80000001, 1'b1, 1'b0, 32'd31, "srl31");
    endtask

    task automatic test_over_range();
        run_op(1'b0, 32'h0F0F0F0F, 1'b1, 1'b0, 32'd34, "srl34");
        run_op(1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd32, "sll32");
        run_op(1'b0, 32'h0F0F0F0F, 1'b0, 1'b0, 32'h00010004, "sll_hi_bits");
        run_op(1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 32'h80000001, "sra_hi_bits_s4");
    endtask

    task automatic test_left();
        run_op(1'b0, 32'h0F0F0F0F, 1'b0, 1'b0, 32'd27, "sll27");
        run_op(1'b1, 32'h0F0F0F0F, 1'b0, 1'b0, 32'd27, "sll27_s4");
        run_op(1'b1, 32'h12345678, 1'b0, 1'b1, 32'd5, "sll5_arith_ignored_s4");
    endtask

    task automatic test_arith();
        run_op(1'b0, 32'hF0000000, 1'b1, 1'b1, 32'd4, "sra4");
        run_op(1'b0, 32'hF0000000, 1'b1, 1'b1, 32'd40, "sra40");
        run_op(1'b0, 32'hF0000000, 1'b1, 1'b0, 32'd4, "srl4");
        run_op(1'b1, 32'h80000000, 1'b1, 1'b1, 32'd9, "sra9_s4");
        run_op(1'b0, 32'h70000000, 1'b1, 1'b1, 32'd3, "sra3_pos");
    endtask

    task automatic test_zero_and_busy();
        use4 = 1'b0;
        run_op(1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 32'd0, "zero_shift");
        run_op(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, "zero_shift_s4");
        use4 = 1'b0;
        // Hold start across the SHIFT and DONE cycles of a zero-length op
        @(negedge clk);
        inp = 32'hDEADBEEF; dir = 1'b0; arith = 1'b0; shiftamt = 32'd0; start1 = 1'b1;
        @(posedge clk); #1;
        inp = 32'h11111111; dir = 1'b1; arith = 1'b1; shiftamt = 32'd3;
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b1 || out1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL busy_start_done: got done=%b out=%h want 1 deadbeef", done1, out1);
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done1 !== 1'b0 || busy1 !== 1'b0 || out1 !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL busy_start_ignored: got done=%b busy=%b out=%h want 0 0 deadbeef",
                         done1, busy1, out1);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic seen;
        use4 = 1'b0;
        @(negedge clk);
        inp = 32'h0F0F0F0F; dir = 1'b1; arith = 1'b0; shiftamt = 32'd20; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || out1 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b out=%h want 0 0 0", busy1, done1, out1);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1 || busy1 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_abort: got done/busy activity after reset want none");
        end
        run_op(1'b0, 32'h0F0F0F0F, 1'b1, 1'b0, 32'd13, "after_reset");
    endtask

    initial begin
        test_reset();
        test_logical_right();
        test_over_range();
        test_left();
        test_arith();
        test_zero_and_busy();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
